// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and the pointer-wrap helper used by
// both the read and write pointer counters.
package fifo_pkg;

  localparam int MEM_SIZE_DEF  = 4;
  localparam int WORD_SIZE_DEF = 6;
  localparam int PTR_DEF       = 3;

  // Explicit wrap at mem_size-1 so non-power-of-two depths work.
  function automatic logic [31:0] next_ptr(input logic [31:0] ptr,
                                           input logic [31:0] mem_size = 32'(MEM_SIZE_DEF));
    logic [31:0] nxt;
    if (ptr == (mem_size - 32'd1)) begin
      nxt = 32'd0;
    end else begin
      nxt = ptr + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// FIFO pointer counter: advances on en, wraps at MEM_SIZE-1, synchronous
// active-low clear. Shared by the read and write sides.
module fifo_ptr_ctr
  import fifo_pkg::*;
#(
  parameter int MEM_SIZE = MEM_SIZE_DEF,
  parameter int PTR      = PTR_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  output logic [PTR-1:0] ptr
);

  logic [PTR-1:0] ptr_d;
  logic [PTR-1:0] ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = PTR'(next_ptr(32'(ptr_q), 32'(MEM_SIZE)));
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= {PTR{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/read_logic.sv
// Read-side control for the synchronous FIFO: pop decision, read pointer and
// registered output word. Define READ_UNDERFLOW_EN to add the sticky underflow flag.
module read_logic
  import fifo_pkg::*;
#(
  parameter int MEM_SIZE  = MEM_SIZE_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int PTR       = PTR_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_rd,
  input  logic                 fifo_wr,
  input  logic                 fifo_empty,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [PTR-1:0]       rd_ptr,
  output logic                 pop,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 data_valid
`ifdef READ_UNDERFLOW_EN
  ,
  output logic                 underflow
`endif
);

  logic                 pop_s;
  logic [WORD_SIZE-1:0] data_out_d;
  logic [WORD_SIZE-1:0] data_out_q;
  logic                 data_valid_d;
  logic                 data_valid_q;

  // A write into an empty FIFO is not yet readable, so fifo_wr never gates the pop.
  logic unused_fifo_wr;
  assign unused_fifo_wr = fifo_wr;

  assign pop_s = reset & fifo_rd & ~fifo_empty;
  assign pop   = pop_s;

  fifo_ptr_ctr #(
    .MEM_SIZE (MEM_SIZE),
    .PTR      (PTR)
  ) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (pop_s),
    .ptr   (rd_ptr)
  );

  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    if (pop_s) begin
      data_out_d   = mem_rdata;
      data_valid_d = 1'b1;
    end else begin
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out_q   <= {WORD_SIZE{1'b0}};
      data_valid_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

`ifdef READ_UNDERFLOW_EN
  logic underflow_d;
  logic underflow_q;

  // Sticky until reset; set by any read attempted while empty.
  always_comb begin
    underflow_d = underflow_q;
    if (fifo_rd & fifo_empty) begin
      underflow_d = 1'b1;
    end else begin
      underflow_d = underflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
    end
  end

  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_read_logic.sv
// Bench for read_logic: directed vector table followed by randomized traffic
// checked against a queue-free arithmetic model of the read side.
module tb_read_logic;
  import fifo_pkg::*;

  localparam int MS = 4;
  localparam int WS = 6;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          reset, fifo_rd, fifo_wr, fifo_empty;
  logic [WS-1:0] mem_rdata, data_out;
  logic [PW-1:0] rd_ptr;
  logic          pop, data_valid;
`ifdef READ_UNDERFLOW_EN
  logic          underflow;
`endif

  logic [WS-1:0] mem [0:7];
  assign mem_rdata = mem[rd_ptr];

  always #5 clk = ~clk;

  read_logic #(.MEM_SIZE(MS), .WORD_SIZE(WS), .PTR(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_rd    (fifo_rd),
    .fifo_wr    (fifo_wr),
    .fifo_empty (fifo_empty),
    .mem_rdata  (mem_rdata),
    .rd_ptr     (rd_ptr),
    .pop        (pop),
    .data_out   (data_out),
    .data_valid (data_valid)
`ifdef READ_UNDERFLOW_EN
    ,
    .underflow  (underflow)
`endif
  );

  int total = 0;
  int bad   = 0;

  int            m_ptr;
  logic [WS-1:0] m_dout;
  logic          m_valid;
  logic          m_uf;
  logic          s_pop;

  typedef struct {
    logic          rst, rd, wr, empty;
    logic          pop;
    int            ptr;
    logic          valid;
    logic [WS-1:0] dout;
    logic          uf;
  } vec_t;

  vec_t vec [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check pop combinationally, advance model, check registers.
  task automatic step(input logic r, input logic rd, input logic wr, input logic e);
    logic exp_pop;
    @(negedge clk);
    reset = r; fifo_rd = rd; fifo_wr = wr; fifo_empty = e;
    #1;
    exp_pop = r & rd & ~e;
    s_pop = pop;
    chk("pop", 32'(pop), 32'(exp_pop));
    if (!r) begin
      m_ptr = 0; m_dout = '0; m_valid = 1'b0; m_uf = 1'b0;
    end else begin
      if (rd && e) m_uf = 1'b1;
      m_valid = exp_pop;
      if (exp_pop) begin
        m_dout = mem[m_ptr];
        m_ptr  = (m_ptr + 1) % MS;
      end
    end
    @(posedge clk);
    #1;
    chk("rd_ptr", 32'(rd_ptr), 32'(m_ptr));
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("data_valid", 32'(data_valid), 32'(m_valid));
`ifdef READ_UNDERFLOW_EN
    chk("underflow", 32'(underflow), 32'(m_uf));
`endif
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    mem[0] = 6'h2A; mem[1] = 6'h15; mem[2] = 6'h33; mem[3] = 6'h0C;
    reset = 1'b0; fifo_rd = 1'b0; fifo_wr = 1'b0; fifo_empty = 1'b1;

    //           rst   rd    wr    empty pop   ptr valid dout   uf
    vec[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 6'h00, 1'b0};
    vec[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 6'h00, 1'b0};
    vec[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1, 6'h2A, 1'b0};
    vec[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 6'h2A, 1'b0};
    vec[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 6'h00, 1'b0};
    vec[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1, 6'h2A, 1'b0};
    vec[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b1, 6'h15, 1'b0};
    vec[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b1, 6'h33, 1'b0};
    vec[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1, 6'h0C, 1'b0};
    vec[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1, 6'h2A, 1'b0};
    vec[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b0, 6'h2A, 1'b1};
    vec[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 6'h2A, 1'b1};
    vec[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b1, 6'h15, 1'b1};
    vec[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b1, 6'h33, 1'b1};
    vec[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1, 6'h0C, 1'b1};
    vec[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1, 6'h2A, 1'b1};
    vec[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b1, 6'h15, 1'b1};
    vec[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 6'h00, 1'b0};
    vec[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 6'h00, 1'b0};

    for (int i = 0; i < 19; i++) begin
      step(vec[i].rst, vec[i].rd, vec[i].wr, vec[i].empty);
      chk($sformatf("tbl%0d_pop", i), 32'(s_pop), 32'(vec[i].pop));
      chk($sformatf("tbl%0d_ptr", i), 32'(rd_ptr), 32'(vec[i].ptr));
      chk($sformatf("tbl%0d_valid", i), 32'(data_valid), 32'(vec[i].valid));
      chk($sformatf("tbl%0d_dout", i), 32'(data_out), 32'(vec[i].dout));
`ifdef READ_UNDERFLOW_EN
      chk($sformatf("tbl%0d_uf", i), 32'(underflow), 32'(vec[i].uf));
`endif
    end

    // Hand-written: long burst of back-to-back pops keeps data_valid high across wraps.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, i[0], 1'b0);
      chk("burst_valid", 32'(data_valid), 32'd1);
    end

    for (int i = 0; i < 400; i++) begin
      mem[$urandom_range(0, MS - 1)] = WS'($urandom);
      step(($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0,
           1'($urandom),
           1'($urandom),
           ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/read_logic.md
# read_logic

Read-side control for the team's synchronous FIFO, the counterpart of the write-side pointer logic. It decides when a word may be popped, advances the read pointer with wrap-around, and registers the addressed memory word into an output stage with a one-cycle valid strobe. It sits between the FIFO memory array, which provides combinational read data at `rd_ptr`, and the consumer. Full/empty flags are computed elsewhere from both pointers.

## Interface
Parameters:
- `MEM_SIZE`, default 4: number of memory entries; the pointer wraps after `MEM_SIZE-1`.
- `WORD_SIZE`, default 6: bits per word.
- `PTR`, default 3: read pointer width; requires `2**PTR >= MEM_SIZE`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `fifo_rd`, input, 1: consumer read request.
- `fifo_wr`, input, 1: producer write request. Observed for the simultaneous-access rules only; it never enables a pop on its own.
- `fifo_empty`, input, 1: FIFO empty indication.
- `mem_rdata`, input, `WORD_SIZE`: memory word at the current `rd_ptr`, combinational.
- `rd_ptr`, output, `PTR`: read pointer (registered).
- `pop`, output, 1: combinational; high when a word is consumed this cycle.
- `data_out`, output, `WORD_SIZE`: registered popped word.
- `data_valid`, output, 1: registered; high for one cycle when `data_out` is new.
- `underflow`, output, 1: sticky read-while-empty error. Present only with `READ_UNDERFLOW_EN`.

## Operation
- `pop = reset & fifo_rd & !fifo_empty`.
  - When the FIFO is empty, a read concurrent with a write does not pop. The word being written is not yet in memory; it becomes readable the next cycle.
  - When the FIFO is not empty, a simultaneous read and write both proceed (push and pop in the same cycle).
- On a rising edge with `pop` high:
  - `rd_ptr <= (rd_ptr == MEM_SIZE-1) ? 0 : rd_ptr + 1`.
  - `data_out <= mem_rdata` (the word at the old `rd_ptr`).
  - `data_valid <= 1`.
- On a rising edge with `pop` low:
  - `rd_ptr` and `data_out` hold.
  - `data_valid <= 0`.
- Pointer arithmetic is `PTR` bits wide. The wrap is explicit at `MEM_SIZE-1`, never by natural overflow, so a non-power-of-two `MEM_SIZE` works.
- Read while empty (`fifo_rd & fifo_empty & reset`): no pop, no pointer move, `data_valid` is 0 on the next cycle. This is an error event (see Configuration).

## Timing
- Reset (`reset` low at a rising edge):
  - `rd_ptr = 0`, `data_out = 0`, `data_valid = 0`, `underflow = 0`.
  - `pop` is forced to 0 combinationally while `reset` is low, in the same cycle.
- Latency: `fifo_rd` is sampled in cycle N with `pop` high. `rd_ptr` is advanced and `data_out`/`data_valid` are valid in cycle N+1.
- Back-to-back reads are supported at one word per cycle. `data_valid` stays high across consecutive pops.
- Reset mid-stream: reset takes priority over a pending pop at the same edge. Nothing is popped and the pointer returns to 0.
- There is no handshake back-pressure on the output. The consumer must take `data_out` in the cycle `data_valid` is high.

## Configuration
- `READ_UNDERFLOW_EN` defined:
  - The `underflow` port exists.
  - It is set at the rising edge after any cycle with `fifo_rd & fifo_empty & reset`.
  - It stays high until reset.
- `READ_UNDERFLOW_EN` undefined: no `underflow` port and no flag register. Reads while empty are silently ignored.

## Structure
- Shared package `fifo_pkg`:
  - Default `MEM_SIZE`/`WORD_SIZE`/`PTR` constants.
  - The pointer-wrap function `next_ptr(ptr)`, used by both the write and read sides.
- One sub-module, `fifo_ptr_ctr`:
  - Inputs: `clk`, `reset`, `en`. Output: pointer.
  - Behaviour: synchronous active-low clear and wrap at `MEM_SIZE-1`.
  - Instantiated here for `rd_ptr` and reusable for the write pointer.
- The output register and underflow flag stay in `read_logic`.

## Test plan
Defaults `MEM_SIZE=4`, `WORD_SIZE=6`, `PTR=3`.
- Reset: hold `reset=0` for 2 cycles with `fifo_rd=1` -> `rd_ptr=0`, `data_out=0`, `data_valid=0`, `pop=0` throughout.
- Single read: memory holds 6'h2A at 0, `fifo_empty=0`, `fifo_rd` pulsed 1 cycle -> `pop=1` that cycle; next cycle `data_out=6'h2A`, `data_valid=1`, `rd_ptr=1`; the cycle after, `data_valid=0`.
- Wrap: 5 consecutive pops with `fifo_empty=0` -> `rd_ptr` sequence 1,2,3,0,1; `data_valid` high for 5 consecutive cycles.
- Empty plus simultaneous write: `fifo_empty=1`, `fifo_rd=1`, `fifo_wr=1` -> `pop=0`, `rd_ptr` unchanged, `data_valid=0`; with `READ_UNDERFLOW_EN`, `underflow=1` next cycle and it remains 1 until reset.
- Non-empty simultaneous access: `fifo_empty=0`, `fifo_rd=1`, `fifo_wr=1`, `rd_ptr=3` -> `pop=1`, `rd_ptr=0` next cycle.
- Reset mid-stream: pops in progress at `rd_ptr=2`, `reset=0` for 1 cycle -> `rd_ptr=0`, `data_valid=0`, `underflow=0` on the following cycle.
